serial_add_ctrl: RTL and testbench
==================================

Name: serial_add_ctrl

Overview:
- Bit-serial add/subtract sequencer that time-shares one 1-bit adder cell across all WIDTH bits of two operands.
- The cell is built from two existing halfadder instances plus an OR gate. halfadder port c is sum and port d is carry.
- The block captures the operands on a start request, steps the cell once per clock from LSB to MSB, and returns the result with a done pulse.
- It sits between a requesting controller and the halfadder datapath and is the only driver of that datapath.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 2..32.

Ports:
- clk     input   1      single system clock, rising edge
- rst     input   1      synchronous reset, active-high
- start   input   1      request; sampled only in IDLE
- sub     input   1      0 = a+b, 1 = a-b; sampled with start
- a_in    input   WIDTH  operand A; sampled with start
- b_in    input   WIDTH  operand B; sampled with start
- busy    output  1      high while in RUN
- done    output  1      one-cycle pulse when the result is valid
- sum     output  WIDTH  result; held stable from done until the next accepted start
- cout    output  1      final carry; for subtract, 1 means no borrow (a >= b)

Behaviour:
- Clocking: one clock; reset is synchronous and active-high (ports clk, rst). rst has priority over every other input on the same edge.
- Reset values: state IDLE, busy 0, done 0, sum 0, cout 0, bit counter 0, internal carry 0, operand shift registers 0.
- States:
  - IDLE -> RUN when start = 1 at an edge.
  - RUN -> DONE at the edge that processes bit WIDTH-1.
  - DONE -> IDLE unconditionally on the next edge.
- Accept edge (IDLE with start = 1):
  - Load A <- a_in.
  - Load B <- b_in when sub = 0, or ~b_in when sub = 1.
  - carry <- sub; counter <- 0; busy <- 1.
- Each RUN edge:
  - Cell inputs are A[0], B[0] and carry. cell_sum = A[0]^B[0]^carry; cell_carry = majority(A[0], B[0], carry).
  - Shift A and B right by one; shift cell_sum into sum[WIDTH-1] while sum shifts right.
  - carry <- cell_carry; counter increments.
- Final RUN edge (counter == WIDTH-1):
  - cout <- cell_carry; state <- DONE; busy <- 0; done <- 1.
- Latency: done is high exactly WIDTH cycles after the accept edge, for exactly one cycle. Throughput is one operation per WIDTH+2 cycles.
- sum is the shift register itself. During RUN it shows partial contents and is only meaningful while done = 1 or afterwards.
- Result arithmetic:
  - sum = (a_in ± b_in) mod 2^WIDTH.
  - For add, cout = bit WIDTH of the true sum.
  - For subtract, cout = 1 iff a_in >= b_in (unsigned).
- start in RUN or DONE is ignored with no queuing. Operand and sub changes after the accept edge have no effect.
- start held high continuously: a new operation is accepted on the first IDLE edge, i.e. every WIDTH+2 cycles.
- rst asserted mid-RUN: next state IDLE, all outputs at reset values, no done pulse. Operation restarts only on a fresh start after rst deasserts.
- rst and start in the same cycle: reset wins and the request is dropped.
- busy and done are never high together. done is never high in IDLE or RUN.

Test Plan (WIDTH = 8):
- Add, no carry: a=0x5A, b=0x3C, sub=0. Required: busy high for 8 cycles, then done=1 with sum=0x96, cout=0, done exactly 8 cycles after the accept edge.
- Add, wrap: a=0xFF, b=0x01, sub=0. Required: sum=0x00, cout=1. Then a=0xFF, b=0xFF gives sum=0xFE, cout=1.
- Subtract: a=0x10, b=0x01, sub=1 gives sum=0x0F, cout=1. Then a=0x01, b=0x02, sub=1 gives sum=0xFF, cout=0. Then a=0x33, b=0x33 gives sum=0x00, cout=1.
- Ignored start: accept a=0x01, b=0x01. At the 3rd RUN cycle pulse start with a=0xF0, b=0x0F. Required: single done with sum=0x02; no second done; state returns to IDLE.
- Reset mid-operation: accept a=0xAA, b=0x55, assert rst at the 4th RUN cycle for 1 cycle. Required: busy=0, done=0, sum=0x00, cout=0 next cycle, and no done afterwards. A new start with a=0x02, b=0x03 then yields sum=0x05.
- Back-to-back: hold start=1 with alternating operands. Required: done pulses spaced exactly 10 cycles apart, each with the correct result; rst together with start on the first cycle delays the first accept by one cycle.

Source files
------------

// File: rtl/serial_add_ctrl_if.sv
// Request/result bundle between a controller and the bit-serial adder.
interface serial_add_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start, sub, a_in, b_in,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, sub, a_in, b_in,
        output busy, done, sum, cout
    );
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract sequencer: one full-adder cell (two half
// adders plus an OR) stepped once per clock from LSB to MSB.
module halfadder (
    input  logic a,
    input  logic b,
    output logic c,
    output logic d
);
    assign c = a ^ b;
    assign d = a & b;
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    serial_add_ctrl_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;

    logic ha0_s, ha0_c, ha1_c;
    logic cell_sum, cell_carry;

    halfadder u_ha0 (
        .a(a_q[0]),
        .b(b_q[0]),
        .c(ha0_s),
        .d(ha0_c)
    );

    halfadder u_ha1 (
        .a(ha0_s),
        .b(carry_q),
        .c(cell_sum),
        .d(ha1_c)
    );

    assign cell_carry = ha0_c | ha1_c;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    a_d     = bus.a_in;
                    // Subtract as a + ~b + 1: the +1 enters as carry-in
                    b_d     = bus.sub ? ~bus.b_in : bus.b_in;
                    carry_d = bus.sub;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                sum_d   = {cell_sum, sum_q[WIDTH-1:1]};
                carry_d = cell_carry;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    cout_d  = cell_carry;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
        end
    end

    assign bus.busy = (state_q == S_RUN);
    assign bus.done = (state_q == S_DONE);
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl (WIDTH = 8): vector table,
// corner-case sequences and randomized ops against an arithmetic model.
module tb_serial_add_ctrl;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    serial_add_ctrl_if #(.WIDTH(W)) dif ();

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk(clk),
        .rst(rst),
        .bus(dif.slave)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       sub;
        logic [7:0] s;
        logic       c;
    } vec_t;

    vec_t vecs[8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // {cout, sum} from plain integer arithmetic
    function automatic logic [8:0] ref_op(input logic [7:0] a,
                                          input logic [7:0] b,
                                          input logic s);
        int unsigned ia, ib, r;
        ia = a;
        ib = b;
        if (!s) begin
            r = ia + ib;
            return r[8:0];
        end
        r = ia - ib;
        return {(ia >= ib), r[7:0]};
    endfunction

    task automatic run_op(input string tag, input logic [7:0] a,
                          input logic [7:0] b, input logic s,
                          input logic [7:0] exp_s, input logic exp_c);
        int lat;
        int busy_n;
        dif.a_in  = a;
        dif.b_in  = b;
        dif.sub   = s;
        dif.start = 1'b1;
        tick();
        dif.start = 1'b0;
        dif.a_in  = 8'($urandom);
        dif.b_in  = 8'($urandom);
        dif.sub   = 1'($urandom);
        lat = 0;
        busy_n = 0;
        while (!dif.done && lat < 20) begin
            if (dif.busy) busy_n++;
            tick();
            lat++;
        end
        chk({tag, " latency"}, lat, 8);
        chk({tag, " busy_cycles"}, busy_n, 8);
        chk({tag, " sum"}, dif.sum, exp_s);
        chk({tag, " cout"}, dif.cout, exp_c);
        chk({tag, " busy_at_done"}, dif.busy, 0);
        tick();
        chk({tag, " done_one_cycle"}, dif.done, 0);
        chk({tag, " sum_held"}, dif.sum, exp_s);
    endtask

    initial begin
        int lat, extra, cyc, last, ndone;
        logic [7:0] ca, cb;
        logic cs;
        logic [8:0] r;

        vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs[2] = '{8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1};
        vecs[3] = '{8'h10, 8'h01, 1'b1, 8'h0F, 1'b1};
        vecs[4] = '{8'h01, 8'h02, 1'b1, 8'hFF, 1'b0};
        vecs[5] = '{8'h33, 8'h33, 1'b1, 8'h00, 1'b1};
        vecs[6] = '{8'h00, 8'h00, 1'b1, 8'h00, 1'b1};
        vecs[7] = '{8'h80, 8'h7F, 1'b0, 8'hFF, 1'b0};

        dif.start = 1'b0;
        dif.sub   = 1'b0;
        dif.a_in  = '0;
        dif.b_in  = '0;
        rst = 1'b1;
        tick();
        tick();
        chk("reset busy", dif.busy, 0);
        chk("reset done", dif.done, 0);
        chk("reset sum", dif.sum, 0);
        chk("reset cout", dif.cout, 0);
        rst = 1'b0;
        tick();

        foreach (vecs[i])
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b,
                   vecs[i].sub, vecs[i].s, vecs[i].c);

        // start pulsed during RUN must be ignored
        dif.a_in = 8'h01;
        dif.b_in = 8'h01;
        dif.sub = 1'b0;
        dif.start = 1'b1;
        tick();
        dif.start = 1'b0;
        tick();
        tick();
        dif.a_in = 8'hF0;
        dif.b_in = 8'h0F;
        dif.start = 1'b1;
        tick();
        dif.start = 1'b0;
        lat = 3;
        while (!dif.done && lat < 20) begin
            tick();
            lat++;
        end
        chk("ign latency", lat, 8);
        chk("ign sum", dif.sum, 8'h02);
        chk("ign cout", dif.cout, 0);
        extra = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (dif.done) extra++;
        end
        chk("ign no_second_done", extra, 0);
        chk("ign idle_busy", dif.busy, 0);

        // reset in the middle of RUN
        dif.a_in = 8'hAA;
        dif.b_in = 8'h55;
        dif.sub = 1'b0;
        dif.start = 1'b1;
        tick();
        dif.start = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst busy", dif.busy, 0);
        chk("midrst done", dif.done, 0);
        chk("midrst sum", dif.sum, 0);
        chk("midrst cout", dif.cout, 0);
        extra = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (dif.done || dif.busy) extra++;
        end
        chk("midrst stays_idle", extra, 0);
        run_op("after_rst", 8'h02, 8'h03, 1'b0, 8'h05, 1'b0);

        // start held high; reset on the first cycle drops that request
        ca = 8'hC3;
        cb = 8'h3C;
        cs = 1'b0;
        dif.a_in = ca;
        dif.b_in = cb;
        dif.sub = cs;
        dif.start = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("b2b rst_wins busy", dif.busy, 0);
        cyc = 0;
        last = 0;
        ndone = 0;
        while (ndone < 6 && cyc < 100) begin
            tick();
            cyc++;
            if (dif.done) begin
                if (ndone == 0) chk("b2b first_done_cycle", cyc, 9);
                else chk("b2b spacing", cyc - last, 10);
                r = ref_op(ca, cb, cs);
                chk($sformatf("b2b%0d sum", ndone), dif.sum, r[7:0]);
                chk($sformatf("b2b%0d cout", ndone), dif.cout, r[8]);
                last = cyc;
                ndone++;
                ca = (ndone % 2) ? 8'($urandom) : 8'h5A;
                cb = (ndone % 2) ? 8'($urandom) : 8'hA5;
                cs = 1'(ndone % 2);
                dif.a_in = ca;
                dif.b_in = cb;
                dif.sub = cs;
            end
        end
        chk("b2b done_count", ndone, 6);
        dif.start = 1'b0;
        for (int i = 0; i < 12; i++) tick();

        for (int i = 0; i < 30; i++) begin
            ca = 8'($urandom);
            cb = 8'($urandom);
            cs = 1'($urandom);
            if (i % 7 == 0) cb = ca;
            r = ref_op(ca, cb, cs);
            run_op($sformatf("rnd%0d", i), ca, cb, cs, r[7:0], r[8]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
